// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: default register
// addresses, status bit positions and the TX state encoding.
package mmio_pkg;

    localparam logic [15:0] DEFAULT_DATA_ADDR   = 16'h0010;
    localparam logic [15:0] DEFAULT_STATUS_ADDR = 16'h0011;

    localparam int ST_FULL = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_OVF  = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full and pop while empty
// are ignored so the caller cannot corrupt the pointers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-attached 8N1 serial transmitter: decodes data/status writes, queues bytes
// in a FIFO and shifts them out LSB first on txd.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a queued byte
// TX_START | start bit (low) for one bit period
// TX_DATA  | eight data bits, LSB first
// TX_STOP  | stop bit (high); chains straight into the next start bit
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] DATA_ADDR    = DEFAULT_DATA_ADDR,
    parameter logic [15:0] STATUS_ADDR  = DEFAULT_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        W,
    input  logic [15:0] word_addr,
    input  logic [31:0] dout,
    output logic [31:0] rdata,
    output logic        rd_hit,
    output logic        txd,
    output logic        busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    tx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit_end;
    logic          pop;

    logic                       push_req;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [7:0]                 fifo_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       overflow_q;
    logic                       clear_ovf;
    logic                       unused_dout_bits;

    assign unused_dout_bits = &{1'b0, dout[31:8]};

    assign rd_hit    = (word_addr == STATUS_ADDR);
    assign push_req  = W && (word_addr == DATA_ADDR);
    assign clear_ovf = W && rd_hit && dout[ST_OVF];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req),
        .pop     (pop),
        .din     (dout[7:0]),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A push that meets a full FIFO is lost even if the FSM pops on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (clear_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    assign busy = (state_q != TX_IDLE) || (fifo_count != '0);

    always_comb begin
        rdata          = '0;
        rdata[ST_FULL] = rd_hit && fifo_full;
        rdata[ST_BUSY] = rd_hit && busy;
        rdata[ST_OVF]  = rd_hit && overflow_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

    // txd is decoded from registered state, so an async reset forces it high at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd     = 1'b1;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    cnt_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            TX_DATA: begin
                txd = shift_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = TX_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_data;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with 4 clocks per bit and a 4-deep FIFO.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [15:0] DA    = 16'h0010;
    localparam logic [15:0] SA    = 16'h0011;

    logic        clk = 1'b0;
    logic        reset;
    logic        W;
    logic [15:0] word_addr;
    logic [31:0] dout;
    logic [31:0] rdata;
    logic        rd_hit;
    logic        txd;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] burst_data [6];

    typedef struct {
        logic        w;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rdata;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .DATA_ADDR    (DA),
        .STATUS_ADDR  (SA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .W         (W),
        .word_addr (word_addr),
        .dout      (dout),
        .rdata     (rdata),
        .rd_hit    (rd_hit),
        .txd       (txd),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected line level k cycles into a frame (k = 1..FRAME).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k <= CPB)          return 1'b0;
        else if (k <= 9 * CPB) return b[(k - CPB - 1) / CPB];
        else                   return 1'b1;
    endfunction

    // Writes burst_data[0..nwr-1] on consecutive edges, then reads status while
    // checking that burst_data[0..nexp-1] go out as contiguous frames.
    task automatic run_burst(input string tag, input int nwr, input int nexp, input bit ovf_test);
        int k;
        int f;
        logic et;
        logic eb;
        logic [31:0] es;
        for (int i = 0; i <= FRAME * nexp + 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                k = i - 1;
                if (k >= 1 && k <= FRAME * nexp) begin
                    f  = (k - 1) / FRAME;
                    et = frame_bit(burst_data[f], k - f * FRAME);
                end else begin
                    et = 1'b1;
                end
                eb = (k <= FRAME * nexp);
                check({tag, " txd"}, {31'b0, txd}, {31'b0, et});
                check({tag, " busy"}, {31'b0, busy}, {31'b0, eb});
                if (i - 1 >= nwr) begin
                    es = {29'b0, ovf_test && (k >= 5), eb, ovf_test && (k >= 4) && (k <= FRAME)};
                    check({tag, " status"}, rdata, es);
                    check({tag, " rd_hit"}, {31'b0, rd_hit}, 32'd1);
                end
            end
            if (i < nwr) begin
                W         = 1'b1;
                word_addr = DA;
                dout      = {24'h5A5A5A, burst_data[i]};
            end else begin
                W         = 1'b0;
                word_addr = SA;
                dout      = '0;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        W         = 1'b0;
        word_addr = SA;
        dout      = '0;
        #1;
        check("reset txd", {31'b0, txd}, 32'd1);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset status", rdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        burst_data[0] = 8'hA5;
        run_burst("single", 1, 1, 1'b0);

        burst_data[0] = 8'h01;
        burst_data[1] = 8'h02;
        burst_data[2] = 8'h03;
        run_burst("b2b", 3, 3, 1'b0);

        burst_data[0] = 8'h11;
        burst_data[1] = 8'h22;
        burst_data[2] = 8'h33;
        burst_data[3] = 8'h44;
        burst_data[4] = 8'h55;
        burst_data[5] = 8'h66;
        run_burst("ovf", 6, 5, 1'b1);

        // Starts idle with overflow still set.
        vecs[0]  = '{1'b0, SA,        32'h0,        1'b1, 32'h4, 1'b0};
        vecs[1]  = '{1'b0, DA,        32'h0,        1'b0, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, 16'h000F,  32'hA5,       1'b0, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 16'h0012,  32'hA5,       1'b0, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, SA,        32'h3,        1'b1, 32'h4, 1'b0};
        vecs[5]  = '{1'b0, SA,        32'h0,        1'b1, 32'h4, 1'b0};
        vecs[6]  = '{1'b0, 16'h0111,  32'h0,        1'b0, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 16'h0110,  32'hFF,       1'b0, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, SA,        32'h4,        1'b1, 32'h4, 1'b0};
        vecs[9]  = '{1'b0, SA,        32'h0,        1'b1, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 16'hFFFF,  32'h0,        1'b0, 32'h0, 1'b0};
        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            W         = vecs[v].w;
            word_addr = vecs[v].addr;
            dout      = vecs[v].wdata;
            #1;
            check($sformatf("vec%0d rd_hit", v), {31'b0, rd_hit}, {31'b0, vecs[v].exp_hit});
            check($sformatf("vec%0d rdata", v), rdata, vecs[v].exp_rdata);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d busy", v), {31'b0, busy}, {31'b0, vecs[v].exp_busy});
            check($sformatf("vec%0d txd", v), {31'b0, txd}, 32'd1);
        end

        // Reset mid-frame, with a zero byte on the line and overflow set.
        burst_data[0] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            W         = 1'b1;
            word_addr = DA;
            dout      = {24'h0, burst_data[0] + 8'(i)};
        end
        @(negedge clk);
        W         = 1'b0;
        word_addr = SA;
        dout      = '0;
        repeat (12) @(negedge clk);
        check("pre-reset txd", {31'b0, txd}, 32'd0);
        check("pre-reset status", rdata, 32'h7);
        #2;
        reset = 1'b1;
        #1;
        check("mid reset txd", {31'b0, txd}, 32'd1);
        check("mid reset busy", {31'b0, busy}, 32'd0);
        check("mid reset status", rdata, 32'd0);
        check("mid reset rd_hit", {31'b0, rd_hit}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("post reset txd", {31'b0, txd}, 32'd1);
        end
        check("post reset busy", {31'b0, busy}, 32'd0);
        check("post reset status", rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
